apb_slave_mem: RTL
==================

// Module: apb_slave_mem
// PURPOSE
//  Parametrised APB3 completer: word-addressed register memory with programmable wait states.
//  Drives PREADY/PSLVERR/PRDATA in response to requester PSEL/PENABLE/PWRITE/PADDR/PWDATA.
//  Sits behind the APB interface as the DUT-side slave model and reusable RTL target.
//  Decodes errors (misaligned / out-of-range) and completes them with PSLVERR.
// PARAMETERS
//  ADDR_WIDTH   8   PADDR width in bits
//  DATA_WIDTH   32  PWDATA/PRDATA width; must be 8, 16, 32 or 64
//  DEPTH        16  number of DATA_WIDTH words; power of two, DEPTH*DATA_WIDTH/8 <= 2**ADDR_WIDTH
//  WAIT_STATES  1   PREADY-low cycles inserted in every access phase (0..15)
// PORTS
//  PCLK     in   1              clock, all state on rising edge
//  PRESETn  in   1              reset, asynchronous, active-low
//  PSEL     in   1              completer select
//  PENABLE  in   1              access phase marker
//  PWRITE   in   1              1 = write, 0 = read
//  PADDR    in   ADDR_WIDTH     byte address
//  PWDATA   in   DATA_WIDTH     write data
//  PSTRB    in   DATA_WIDTH/8   byte strobes (only with APB_SLAVE_PSTRB_EN)
//  PRDATA   out  DATA_WIDTH     read data, valid only when PREADY=1 on a read
//  PREADY   out  1              transfer completes this cycle
//  PSLVERR  out  1              transfer error, valid only when PREADY=1
// BEHAVIOUR
//  Reset: PREADY=0, PSLVERR=0, PRDATA=0, all memory words=0, FSM=IDLE, wait counter=0.
//  Async reset mid-transfer aborts it; no write occurs; first transfer after release starts at SETUP.
//  FSM states: IDLE, SETUP, ACCESS.
//   IDLE  : PSEL=1 & PENABLE=0 -> SETUP; capture PADDR/PWRITE/PWDATA; load cnt=WAIT_STATES;
//           PREADY <= (WAIT_STATES==0). PSEL=1 & PENABLE=1 in IDLE: ignored, stays IDLE.
//   SETUP : -> ACCESS unconditionally (requester holds PENABLE=1).
//   ACCESS: PREADY=0 -> cnt--; PREADY <= (cnt==1). PREADY=1 sampled at edge -> transfer done,
//           PREADY<=0, PSLVERR<=0, PRDATA<=0; next = SETUP if PSEL&!PENABLE, else IDLE.
//           PSEL dropped while PREADY=0: abort, no write, -> IDLE.
//  All outputs registered; transfer takes 2+WAIT_STATES cycles from SETUP to completion edge.
//  Decode: ALIGN=$clog2(DATA_WIDTH/8); index=PADDR[ALIGN+$clog2(DEPTH)-1:ALIGN].
//  Error if PADDR[ALIGN-1:0]!=0 or PADDR>=DEPTH*(DATA_WIDTH/8); computed at SETUP capture.
//  Error transfer: PSLVERR=1 with PREADY; write suppressed; PRDATA=0.
//  Write: memory updated on the completion edge (PREADY=1 sampled), never earlier.
//  Read: PRDATA loaded with mem[index] together with PREADY rising; back-to-back write->read
//  of same index returns new data.
//  PSLVERR and PRDATA are 0 whenever PREADY=0.
// CONFIGURATION
//  APB_SLAVE_PSTRB_EN defined: PSTRB port present; write updates byte lanes with PSTRB[i]=1 only;
//   read with PSTRB!=0 -> PSLVERR=1 (APB4 rule).
//  Undefined: no PSTRB port; every write updates the full word.
// STRUCTURE
//  apb_pkg: typedef enum logic[1:0] {IDLE,SETUP,ACCESS} apb_state_e; default ADDR/DATA width
//   localparams; function apb_addr_err(addr) shared with the bench scoreboard.
//  Sub-module apb_slave_regbank: DEPTH x DATA_WIDTH array, async clear, byte-enable write port,
//   single read port; FSM, decode and wait counter stay in apb_slave_mem.
// TESTING
//  Reset: PRESETn=0 -> PREADY=0, PSLVERR=0, PRDATA=0; read every index after release -> 0.
//  WAIT_STATES=0: write 0xDEADBEEF @0x04, read @0x04 -> PREADY high in first ACCESS cycle, PRDATA=0xDEADBEEF.
//  WAIT_STATES=3: read @0x08 -> PREADY low 3 ACCESS cycles, high on 4th; total 5 cycles.
//  Error: write @0x41 (misaligned) and @0x40 (DEPTH=16) -> PSLVERR=1 with PREADY, memory unchanged.
//  Abort: PRESETn low during ACCESS of write @0x0C -> readback @0x0C = 0; PSEL drop mid-wait -> IDLE, no write.
//  PSTRB_EN: mem@0x00=0x11223344, write 0xAABBCCDD PSTRB=4'b0101 -> read 0x11BB33DD.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types, default widths and the address-decode rule for the APB register-memory completer.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int unsigned APB_ADDR_WIDTH = 8;
    localparam int unsigned APB_DATA_WIDTH = 32;
    localparam int unsigned APB_CNT_WIDTH  = 4;

    // Misaligned (low address bits set) or beyond the last word of the memory.
    function automatic logic apb_addr_err(input logic [31:0] addr,
                                          input int unsigned bytes_per_word,
                                          input int unsigned depth);
        logic w_misaligned;
        logic w_out_of_range;
        w_misaligned   = (addr & 32'(bytes_per_word - 1)) != 32'd0;
        w_out_of_range = addr >= 32'(depth * bytes_per_word);
        return w_misaligned || w_out_of_range;
    endfunction

endpackage

// File: rtl/apb_slave_regbank.sv
// DEPTH x DATA_WIDTH register array: async clear, byte-enable write port, combinational read.
module apb_slave_regbank
    import apb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned IDX_W      = $clog2(DEPTH)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_we,
    input  logic [IDX_W-1:0]        i_wr_idx,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    input  logic [DATA_WIDTH/8-1:0] i_wr_strb,
    input  logic [IDX_W-1:0]        i_rd_idx,
    output logic [DATA_WIDTH-1:0]   o_rd_data
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if (i_wr_strb[b]) begin
                    r_mem[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
                end
            end
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer: word-addressed register memory with programmable wait states and error decode.
// Define APB_SLAVE_PSTRB_EN to add the APB4 PSTRB port (byte-lane writes, strobed reads error).
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = APB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = APB_DATA_WIDTH,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_SLAVE_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam int unsigned ALIGN  = $clog2(NBYTES);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam logic [APB_CNT_WIDTH-1:0] CNT_LOAD = APB_CNT_WIDTH'(WAIT_STATES);
    localparam logic [APB_CNT_WIDTH-1:0] CNT_LAST = APB_CNT_WIDTH'(1);

    apb_state_e                r_state;
    logic [APB_CNT_WIDTH-1:0]  r_cnt;
    logic                      r_write;
    logic                      r_err;
    logic [IDX_W-1:0]          r_idx;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [NBYTES-1:0]         r_strb;
    logic                      r_pready;
    logic                      r_pslverr;
    logic [DATA_WIDTH-1:0]     r_prdata;

    logic [NBYTES-1:0]         w_strb;
    logic                      w_strb_err;
    logic                      w_req_err;
    logic [IDX_W-1:0]          w_pidx;
    logic                      w_setup_req;
    logic                      w_done;
    logic                      w_capture;
    logic                      w_we;
    logic [IDX_W-1:0]          w_rd_idx;
    logic [DATA_WIDTH-1:0]     w_mem_rdata;
    logic [DATA_WIDTH-1:0]     w_wmask;
    logic [DATA_WIDTH-1:0]     w_rd_data;

`ifdef APB_SLAVE_PSTRB_EN
    assign w_strb     = PSTRB;
    assign w_strb_err = !PWRITE && (PSTRB != '0);
`else
    assign w_strb     = '1;
    assign w_strb_err = 1'b0;
`endif

    assign w_req_err   = apb_addr_err(32'(PADDR), NBYTES, DEPTH) || w_strb_err;
    assign w_pidx      = PADDR[ALIGN +: IDX_W];
    assign w_setup_req = PSEL && !PENABLE;
    assign w_done      = (r_state == ACCESS) && r_pready;
    // A new request may be accepted on the same edge that retires the previous one.
    assign w_capture   = w_setup_req && ((r_state == IDLE) || w_done);
    assign w_we        = w_done && r_write && !r_err;
    assign w_rd_idx    = w_capture ? w_pidx : r_idx;

    always_comb begin
        w_wmask = '0;
        for (int unsigned b = 0; b < NBYTES; b++) begin
            w_wmask[b*8 +: 8] = {8{r_strb[b]}};
        end
    end

    // With zero wait states a read can be captured on the edge that commits a write to the
    // same word, so forward the merged write data instead of the stale array contents.
    always_comb begin
        w_rd_data = w_mem_rdata;
        if (w_we && (r_idx == w_rd_idx)) begin
            w_rd_data = (w_mem_rdata & ~w_wmask) | (r_wdata & w_wmask);
        end
    end

    apb_slave_regbank #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_regbank (
        .i_clk      (PCLK),
        .i_rst_n    (PRESETn),
        .i_we       (w_we),
        .i_wr_idx   (r_idx),
        .i_wr_data  (r_wdata),
        .i_wr_strb  (r_strb),
        .i_rd_idx   (w_rd_idx),
        .o_rd_data  (w_mem_rdata)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_state <= IDLE;
                end
                SETUP: begin
                    r_state <= ACCESS;
                end
                ACCESS: begin
                    if (r_pready) begin
                        r_state   <= IDLE;
                        r_pready  <= 1'b0;
                        r_pslverr <= 1'b0;
                        r_prdata  <= '0;
                    end else if (!PSEL) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            r_pready  <= 1'b1;
                            r_pslverr <= r_err;
                            r_prdata  <= (r_write || r_err) ? '0 : w_rd_data;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Later assignments win: a capture overrides the retire/idle updates above.
            if (w_capture) begin
                r_state <= SETUP;
                r_write <= PWRITE;
                r_err   <= w_req_err;
                r_idx   <= w_pidx;
                r_wdata <= PWDATA;
                r_strb  <= w_strb;
                r_cnt   <= CNT_LOAD;
                if (WAIT_STATES == 0) begin
                    r_pready  <= 1'b1;
                    r_pslverr <= w_req_err;
                    r_prdata  <= (PWRITE || w_req_err) ? '0 : w_rd_data;
                end else begin
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    r_prdata  <= '0;
                end
            end
        end
    end

    assign PREADY  = r_pready;
    assign PSLVERR = r_pslverr;
    assign PRDATA  = r_prdata;

endmodule
